// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO PHY-side responder.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_PRE   = 3'd0,
    S_ST    = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6,
    S_SKIP  = 3'd7
  } mdio_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [4:0] REG_BMCR    = 5'd0;
  localparam logic [4:0] REG_BMSR    = 5'd1;
  localparam logic [4:0] REG_ID1     = 5'd2;
  localparam logic [4:0] REG_ID2     = 5'd3;
  localparam logic [4:0] REG_ANAR    = 5'd4;
  localparam logic [4:0] REG_SCRATCH = 5'd31;

  localparam logic [15:0] BMCR_DEF    = 16'h3100;
  localparam logic [15:0] BMSR_BASE   = 16'h7809;
  localparam logic [15:0] ANAR_DEF    = 16'h01E1;
  localparam logic [15:0] SCRATCH_DEF = 16'h0000;

  // TA (2) plus data (16) edges swallowed by a frame not meant for us.
  localparam logic [7:0] SKIP_EDGES = 8'd18;

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings MDC and MDIO into the fabric clock domain and flags MDC rising edges.
module mdio_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdio_o,
  output logic mdc_rise_o
);

  logic [2:0] mdc_q;
  logic [1:0] mdio_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdc_q  <= 3'b000;
      mdio_q <= 2'b11;
    end else begin
      mdc_q  <= {mdc_q[1:0], mdc_i};
      mdio_q <= {mdio_q[0], mdio_i};
    end
  end

  // MDIO tap sits at the same depth as the MDC edge so the sampled bit lines up.
  assign mdc_rise_o = mdc_q[1] & ~mdc_q[2];
  assign mdio_o     = mdio_q[1];

endmodule

// File: rtl/mdio_phy_resp.sv
// Clause-22 MDIO PHY-side responder with a small register file.
// Optional: define MDIO_PRE_SUPPRESS_EN to accept preamble-suppressed frames.
module mdio_phy_resp
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0007,
  parameter logic [15:0] PHY_ID2  = 16'hC0F1,
  parameter int unsigned PRE_LEN  = 32
) (
  input  logic        Clk,
  input  logic        Rstn,
  input  logic        MDC,
  input  logic        Mdio_I,
  output logic        Mdio_O,
  output logic        Mdio_Oe,
  input  logic        Link_Up,
  output logic        Wr_Strb,
  output logic [4:0]  Wr_Reg_Addr,
  output logic [15:0] Wr_Data,
  output logic        Rd_Strb,
  output logic        Frame_Err,
  output logic        Busy
);

  localparam logic [7:0] PRE_MAX = 8'(PRE_LEN);

  logic mdio_s, mdc_rise;

  mdio_edge_sync u_sync (
    .clk_i      (Clk),
    .rst_ni     (Rstn),
    .mdc_i      (MDC),
    .mdio_i     (Mdio_I),
    .mdio_o     (mdio_s),
    .mdc_rise_o (mdc_rise)
  );

  mdio_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  addr_q, addr_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [15:0] sh_q, sh_d;
  logic        is_rd_q, is_rd_d;
  logic [15:0] bmcr_q, bmcr_d, anar_q, anar_d, scr_q, scr_d;
  logic        oe_q, oe_d, o_q, o_d;
  logic        wr_strb_q, wr_strb_d, rd_strb_q, rd_strb_d, ferr_q, ferr_d;
  logic        busy_q, busy_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;

  logic [4:0]  addr_nxt;
  logic [15:0] wr_word;
  logic        pre_ok;

  assign addr_nxt = {addr_q[3:0], mdio_s};
  assign wr_word  = {sh_q[14:0], mdio_s};

`ifdef MDIO_PRE_SUPPRESS_EN
  assign pre_ok = (cnt_q != 8'd0);
`else
  assign pre_ok = (cnt_q == PRE_MAX);
`endif

  function automatic logic [15:0] reg_read(input logic [4:0]  a,
                                           input logic [15:0] bmcr,
                                           input logic [15:0] anar,
                                           input logic [15:0] scr,
                                           input logic        link);
    logic [15:0] rv;
    rv = 16'h0000;
    case (a)
      REG_BMCR:    rv = bmcr & 16'h7FFF;
      REG_BMSR:    rv = BMSR_BASE | {13'd0, link, 2'b00};
      REG_ID1:     rv = PHY_ID1;
      REG_ID2:     rv = PHY_ID2;
      REG_ANAR:    rv = anar;
      REG_SCRATCH: rv = scr;
      default:     rv = 16'h0000;
    endcase
    return rv;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    reg_addr_d = reg_addr_q;
    sh_d       = sh_q;
    is_rd_d    = is_rd_q;
    bmcr_d     = bmcr_q;
    anar_d     = anar_q;
    scr_d      = scr_q;
    oe_d       = oe_q;
    o_d        = o_q;
    wr_strb_d  = 1'b0;
    rd_strb_d  = 1'b0;
    ferr_d     = 1'b0;
    busy_d     = busy_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (mdc_rise) begin
      case (state_q)
        S_PRE: begin
          if (mdio_s) begin
            if (cnt_q != PRE_MAX) cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = 8'd0;
            if (pre_ok) begin
              state_d = S_ST;
              busy_d  = 1'b1;
            end
          end
        end
        S_ST: begin
          cnt_d = 8'd0;
          if (mdio_s) begin
            state_d = S_OP;
          end else begin
            ferr_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_PRE;
          end
        end
        S_OP: begin
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd1) begin
            cnt_d = 8'd0;
            case (addr_nxt[1:0])
              OP_READ:  begin is_rd_d = 1'b1; state_d = S_PHYAD; end
              OP_WRITE: begin is_rd_d = 1'b0; state_d = S_PHYAD; end
              default:  begin ferr_d = 1'b1; state_d = S_SKIP; end
            endcase
          end
        end
        S_PHYAD: begin
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd4) begin
            cnt_d   = 8'd0;
            state_d = (addr_nxt == PHY_ADDR) ? S_REGAD : S_SKIP;
          end
        end
        S_REGAD: begin
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd4) begin
            cnt_d      = 8'd0;
            reg_addr_d = addr_nxt;
            state_d    = S_TA;
            if (is_rd_q) sh_d = reg_read(addr_nxt, bmcr_q, anar_q, scr_q, Link_Up);
          end
        end
        S_TA: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd0) begin
            if (is_rd_q) begin
              oe_d      = 1'b1;
              o_d       = 1'b0;
              rd_strb_d = 1'b1;
            end
          end else begin
            cnt_d   = 8'd0;
            state_d = S_DATA;
            if (is_rd_q) begin
              o_d  = sh_q[15];
              sh_d = {sh_q[14:0], 1'b0};
            end
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + 8'd1;
          if (is_rd_q) begin
            if (cnt_q == 8'd15) begin
              oe_d    = 1'b0;
              o_d     = 1'b1;
              cnt_d   = 8'd0;
              busy_d  = 1'b0;
              state_d = S_PRE;
            end else begin
              o_d  = sh_q[15];
              sh_d = {sh_q[14:0], 1'b0};
            end
          end else begin
            sh_d = wr_word;
            if (cnt_q == 8'd15) begin
              wr_strb_d = 1'b1;
              wr_addr_d = reg_addr_q;
              wr_data_d = wr_word;
              cnt_d     = 8'd0;
              busy_d    = 1'b0;
              state_d   = S_PRE;
              case (reg_addr_q)
                REG_BMCR: begin
                  // Soft reset restores the writable registers in the same cycle.
                  if (wr_word[15]) begin
                    bmcr_d = BMCR_DEF;
                    anar_d = ANAR_DEF;
                    scr_d  = SCRATCH_DEF;
                  end else begin
                    bmcr_d = wr_word;
                  end
                end
                REG_ANAR:    anar_d = wr_word;
                REG_SCRATCH: scr_d  = wr_word;
                default: ;
              endcase
            end
          end
        end
        S_SKIP: begin
          oe_d  = 1'b0;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == SKIP_EDGES - 8'd1) begin
            cnt_d   = 8'd0;
            busy_d  = 1'b0;
            state_d = S_PRE;
          end
        end
        default: state_d = S_PRE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state_q    <= S_PRE;
      cnt_q      <= 8'd0;
      addr_q     <= 5'd0;
      reg_addr_q <= 5'd0;
      sh_q       <= 16'h0000;
      is_rd_q    <= 1'b0;
      bmcr_q     <= BMCR_DEF;
      anar_q     <= ANAR_DEF;
      scr_q      <= SCRATCH_DEF;
      oe_q       <= 1'b0;
      o_q        <= 1'b1;
      wr_strb_q  <= 1'b0;
      rd_strb_q  <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      reg_addr_q <= reg_addr_d;
      sh_q       <= sh_d;
      is_rd_q    <= is_rd_d;
      bmcr_q     <= bmcr_d;
      anar_q     <= anar_d;
      scr_q      <= scr_d;
      oe_q       <= oe_d;
      o_q        <= o_d;
      wr_strb_q  <= wr_strb_d;
      rd_strb_q  <= rd_strb_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign Mdio_O      = o_q;
  assign Mdio_Oe     = oe_q;
  assign Wr_Strb     = wr_strb_q;
  assign Wr_Reg_Addr = wr_addr_q;
  assign Wr_Data     = wr_data_q;
  assign Rd_Strb     = rd_strb_q;
  assign Frame_Err   = ferr_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_mdio_phy_resp.sv
// Directed plus randomized bench for mdio_phy_resp acting as an MDIO master.
module tb_mdio_phy_resp;

  localparam logic [4:0] PHY = 5'd1;

  logic        Clk = 1'b0;
  logic        Rstn, MDC, Mdio_I, Mdio_O, Mdio_Oe, Link_Up;
  logic        Wr_Strb, Rd_Strb, Frame_Err, Busy;
  logic [4:0]  Wr_Reg_Addr;
  logic [15:0] Wr_Data;
  logic        m_oe, m_val;

  always #5 Clk = ~Clk;

  // Open-drain style bus with pull-up when nobody drives.
  assign Mdio_I = Mdio_Oe ? Mdio_O : (m_oe ? m_val : 1'b1);

  mdio_phy_resp dut (
    .Clk(Clk), .Rstn(Rstn), .MDC(MDC), .Mdio_I(Mdio_I), .Mdio_O(Mdio_O),
    .Mdio_Oe(Mdio_Oe), .Link_Up(Link_Up), .Wr_Strb(Wr_Strb),
    .Wr_Reg_Addr(Wr_Reg_Addr), .Wr_Data(Wr_Data), .Rd_Strb(Rd_Strb),
    .Frame_Err(Frame_Err), .Busy(Busy)
  );

  int n_cmp = 0, n_err = 0;
  int rd_cnt = 0, wr_cnt = 0, fe_cnt = 0, oe_cyc = 0, contention = 0;
  logic [4:0]  cap_addr = 5'd0;
  logic [15:0] cap_data = 16'h0;
  logic [15:0] m_bmcr, m_anar, m_scr;
  logic [15:0] last_rd;
  logic        ab_oe_before, ab_oe, ab_o;

  always @(negedge Clk) begin
    if (Rd_Strb)   rd_cnt++;
    if (Frame_Err) fe_cnt++;
    if (Mdio_Oe)   oe_cyc++;
    if (Mdio_Oe && m_oe) contention++;
    if (Wr_Strb) begin
      wr_cnt++;
      cap_addr = Wr_Reg_Addr;
      cap_data = Wr_Data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference register file, described by the register map rules.
  task automatic m_reset();
    m_bmcr = 16'h3100; m_anar = 16'h01E1; m_scr = 16'h0000;
  endtask

  function automatic logic [15:0] m_read(input logic [4:0] a, input logic link);
    case (a)
      5'd0:    return m_bmcr & 16'h7FFF;
      5'd1:    return 16'h7809 | (link ? 16'h0004 : 16'h0000);
      5'd2:    return 16'h0007;
      5'd3:    return 16'hC0F1;
      5'd4:    return m_anar;
      5'd31:   return m_scr;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0) begin
      if (d[15]) m_reset();
      else       m_bmcr = d;
    end else if (a == 5'd4)  m_anar = d;
    else if (a == 5'd31)     m_scr  = d;
  endtask

  task automatic mdc_bit(input logic drive, input logic val, output logic smp);
    m_oe = drive; m_val = val;
    repeat (6) @(negedge Clk);
    smp = Mdio_I;
    MDC = 1'b1;
    repeat (6) @(negedge Clk);
    MDC = 1'b0;
  endtask

  task automatic frame(input int pre_n, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [15:0] wd, input int abort_k,
                       output logic [15:0] rd, output logic ta2, output logic busy_mid);
    logic s;
    logic [13:0] hdr;
    logic is_rd;
    hdr = {2'b01, op, phy, rg};
    is_rd = (op == 2'b10);
    rd = 16'hFFFF; ta2 = 1'b1; busy_mid = 1'b0;
    for (int i = 0; i < pre_n; i++) mdc_bit(1'b1, 1'b1, s);
    for (int i = 13; i >= 0; i--) begin
      mdc_bit(1'b1, hdr[i], s);
      if (i == 3) busy_mid = Busy;
    end
    if (is_rd) begin
      mdc_bit(1'b0, 1'b1, s);
      mdc_bit(1'b0, 1'b1, ta2);
    end else begin
      mdc_bit(1'b1, 1'b1, s);
      mdc_bit(1'b1, 1'b0, ta2);
    end
    for (int k = 0; k < 16; k++) begin
      if (k == abort_k) begin
        m_oe = 1'b0;
        repeat (3) @(negedge Clk);
        ab_oe_before = Mdio_Oe;
        #2 Rstn = 1'b0;
        #1 begin ab_oe = Mdio_Oe; ab_o = Mdio_O; end
        return;
      end
      if (is_rd) begin
        mdc_bit(1'b0, 1'b1, s);
        rd[15-k] = s;
      end else begin
        mdc_bit(1'b1, wd[15-k], s);
      end
    end
    m_oe = 1'b0;
    repeat (12) @(negedge Clk);
  endtask

  task automatic rd_check(input string tag, input logic [4:0] rg);
    logic [15:0] rd, expv;
    logic ta2, bm;
    int r0;
    r0 = rd_cnt;
    expv = m_read(rg, Link_Up);
    frame(32, 2'b10, PHY, rg, 16'h0, -1, rd, ta2, bm);
    last_rd = rd;
    chk({tag, "_data"}, rd, expv);
    chk({tag, "_ta2"}, ta2, 0);
    chk({tag, "_rdstrb"}, rd_cnt - r0, 1);
    chk({tag, "_busymid"}, bm, 1);
    chk({tag, "_oe_end"}, Mdio_Oe, 0);
    chk({tag, "_busy_end"}, Busy, 0);
  endtask

  task automatic wr_do(input string tag, input logic [4:0] rg, input logic [15:0] d);
    logic [15:0] rd;
    logic ta2, bm;
    int w0;
    w0 = wr_cnt;
    frame(32, 2'b01, PHY, rg, d, -1, rd, ta2, bm);
    m_write(rg, d);
    chk({tag, "_wrstrb"}, wr_cnt - w0, 1);
    chk({tag, "_wraddr"}, cap_addr, rg);
    chk({tag, "_wrdata"}, cap_data, d);
  endtask

  initial begin
    logic [15:0] rd;
    logic ta2, bm;
    int r0, o0, f0;
    logic [4:0] rg, bad_phy;
    logic [15:0] d;
    logic [4:0] tbl [6];

    tbl[0] = 5'd0; tbl[1] = 5'd1; tbl[2] = 5'd2;
    tbl[3] = 5'd3; tbl[4] = 5'd4; tbl[5] = 5'd31;
    Rstn = 1'b0; MDC = 1'b0; m_oe = 1'b0; m_val = 1'b1; Link_Up = 1'b0;
    m_reset();
    repeat (4) @(negedge Clk);
    chk("rst_oe", Mdio_Oe, 0);
    chk("rst_o", Mdio_O, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_strobes", {Wr_Strb, Rd_Strb, Frame_Err}, 0);
    chk("rst_wraddr", Wr_Reg_Addr, 0);
    chk("rst_wrdata", Wr_Data, 0);
    Rstn = 1'b1;
    repeat (4) @(negedge Clk);

    rd_check("id1", 5'd2);
    chk("id1_const", last_rd, 16'h0007);

    wr_do("scr_wr", 5'd31, 16'hA5A5);
    rd_check("scr_rd", 5'd31);
    chk("scr_const", last_rd, 16'hA5A5);

    wr_do("anar_wr", 5'd4, 16'h0000);
    rd_check("anar_zero", 5'd4);
    wr_do("bmcr_rst", 5'd0, 16'h8000);
    rd_check("bmcr_def", 5'd0);
    chk("bmcr_const", last_rd, 16'h3100);
    rd_check("anar_def", 5'd4);
    chk("anar_const", last_rd, 16'h01E1);

    r0 = rd_cnt; o0 = oe_cyc;
    frame(32, 2'b10, 5'd5, 5'd1, 16'h0, -1, rd, ta2, bm);
    chk("misaddr_oe", oe_cyc - o0, 0);
    chk("misaddr_rdstrb", rd_cnt - r0, 0);
    Link_Up = 1'b1;
    rd_check("bmsr", 5'd1);
    chk("bmsr_const", last_rd, 16'h780D);

    f0 = fe_cnt; o0 = oe_cyc;
    frame(32, 2'b11, PHY, 5'd2, 16'hFFFF, -1, rd, ta2, bm);
    chk("op11_ferr", fe_cnt - f0, 1);
    chk("op11_oe", oe_cyc - o0, 0);
    rd_check("id2", 5'd3);

    r0 = rd_cnt; o0 = oe_cyc;
    frame(31, 2'b10, PHY, 5'd2, 16'h0, -1, rd, ta2, bm);
`ifdef MDIO_PRE_SUPPRESS_EN
    chk("shortpre_data", rd, 16'h0007);
    chk("shortpre_rdstrb", rd_cnt - r0, 1);
`else
    chk("shortpre_oe", oe_cyc - o0, 0);
    chk("shortpre_rdstrb", rd_cnt - r0, 0);
`endif

    for (int it = 0; it < 24; it++) begin
      Link_Up = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6) rg = tbl[$urandom_range(0, 5)];
      else                          rg = 5'($urandom_range(5, 30));
      d = 16'($urandom);
      case ($urandom_range(0, 4))
        0: begin
          bad_phy = PHY ^ 5'($urandom_range(1, 31));
          r0 = rd_cnt; o0 = oe_cyc;
          frame(32, 2'b10, bad_phy, rg, 16'h0, -1, rd, ta2, bm);
          chk("rnd_misaddr_oe", oe_cyc - o0, 0);
          chk("rnd_misaddr_rd", rd_cnt - r0, 0);
        end
        1, 2: wr_do("rnd_wr", rg, d);
        default: rd_check("rnd_rd", rg);
      endcase
    end

    wr_do("pre_abort_wr", 5'd31, 16'h5A3C);
    frame(32, 2'b10, PHY, 5'd31, 16'h0, 8, rd, ta2, bm);
    chk("abort_oe_before", ab_oe_before, 1);
    chk("abort_oe_async", ab_oe, 0);
    chk("abort_o_async", ab_o, 1);
    repeat (4) @(negedge Clk);
    Rstn = 1'b1;
    m_reset();
    repeat (4) @(negedge Clk);
    rd_check("post_rst_scr", 5'd31);
    rd_check("post_rst_id1", 5'd2);

    chk("bus_contention", contention, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdio_phy_resp.md
Name: mdio_phy_resp

Overview:
Clause-22 MDIO target (PHY-side responder): the opposite end of the existing MDIO management master.
- Oversamples MDC/MDIO in the fabric clock and decodes management frames addressed to its PHY address.
- Serves reads from a small internal register file and applies writes.
- Used as a synthesizable PHY-management model in loopback builds and on the verification bench.

Parameters:
PHY_ADDR, 5'd1, PHY address this responder answers to.
PHY_ID1, 16'h0007, read-only value of register 2.
PHY_ID2, 16'hC0F1, read-only value of register 3.
PRE_LEN, 32, consecutive preamble ones required before ST.

Ports:
Clk  in  1  fabric clock; must be at least 8x MDC frequency.
Rstn  in  1  reset; asynchronous assert, active-low.
MDC  in  1  management clock from master; asynchronous to Clk.
Mdio_I  in  1  MDIO pad input.
Mdio_O  out  1  MDIO drive value.
Mdio_Oe  out  1  MDIO output enable; top-level tristate drives the pad when 1.
Link_Up  in  1  link status, reflected in reg1 bit 2.
Wr_Strb  out  1  one-Clk pulse when a write frame to this PHY completes.
Wr_Reg_Addr  out  5  register address of the last write.
Wr_Data  out  16  data of the last write.
Rd_Strb  out  1  one-Clk pulse when read data output begins (TA bit 2).
Frame_Err  out  1  one-Clk pulse on a bad ST or OP.
Busy  out  1  high from ST detection until frame end.

Behaviour:
- Reset values:
  - Mdio_Oe=0, Mdio_O=1, all strobes=0, Wr_Reg_Addr=0, Wr_Data=0, Busy=0.
  - State PRE, preamble count 0, registers at defaults.
  - Reset is asynchronous, so assertion mid-frame releases MDIO immediately.
- Input path:
  - MDC and Mdio_I pass through 2-flop synchronizers.
  - A bit is sampled on the detected MDC rising edge (one-Clk edge pulse).
- Drive path: Mdio_O/Mdio_Oe update one Clk cycle after the edge pulse. This keeps data stable for the master's next rising edge.
- FSM:
  - PRE: count consecutive 1s, saturating at PRE_LEN. A 0 with count<PRE_LEN clears the count. A 0 with count=PRE_LEN goes to ST; Busy=1.
  - ST: 1 goes to OP. 0 raises Frame_Err and goes to PRE with count 0.
  - OP: 2 bits MSB-first. 10=read, 01=write. 00/11 raise Frame_Err and go to SKIP.
  - PHYAD: 5 bits. On the 5th bit, a mismatch with PHY_ADDR goes to SKIP.
  - REGAD: 5 bits, then TA.
  - TA, read frame:
    - After the TA1 edge: Oe=1, O=0, Rd_Strb pulse.
    - After the TA2 edge: O=data[15].
  - TA, write frame: ignore both TA bits.
  - DATA:
    - Read: shift out bit 14..0 on each edge. After the edge that samples D0, Oe=0, O=1, go to PRE.
    - Write: shift in 16 bits MSB-first. On the 16th bit apply the write, pulse Wr_Strb, go to PRE.
  - SKIP: count 18 edges (TA+data) with Oe=0, then go to PRE.
  - Busy clears on return to PRE. The preamble count is 0 after every frame.
- Register map:
  - reg0 BMCR: RW, default 16'h3100.
    - Writing bit15=1 restores reg0/reg4/reg31 to defaults in the same cycle as the write.
    - Bit 15 always reads 0.
  - reg1 BMSR: RO, reads 16'h7809 | (Link_Up<<2).
  - reg2 and reg3: RO, read PHY_ID1 and PHY_ID2.
  - reg4 ANAR: RW, default 16'h01E1.
  - reg31: RW scratch, default 0.
  - Regs 5–30: read 16'h0000; writes ignored except Wr_Strb still pulses.
  - Writes to RO regs are ignored; Wr_Strb still pulses.
- Read data is captured into the shift register when REGAD completes.
- MDC stopping mid-frame: state holds indefinitely; no timeout.

Optional Feature:
MDIO_PRE_SUPPRESS_EN
- Defined: in PRE, a 0 following at least one 1 goes to ST regardless of count, which supports preamble-suppressed masters.
- Undefined: the full PRE_LEN ones are required.

Decomposition:
- Package mdio_pkg holds:
  - state enum: PRE, ST, OP, PHYAD, REGAD, TA, DATA, SKIP.
  - OP_READ and OP_WRITE constants.
  - register address constants (REG_BMCR, REG_BMSR, REG_ID1, REG_ID2, REG_ANAR, REG_SCRATCH).
  - register default constants.
  - 18-edge SKIP length constant.
- One sub-module, mdio_edge_sync: synchronizes MDC/Mdio_I and outputs sync'd MDIO plus the MDC rising-edge pulse.

Test Plan:
- Read reg2 at PHY_ADDR=1 with 32-one preamble → Oe rises after TA1, TA2 reads 0, data 16'h0007, Oe drops after D0; one Rd_Strb pulse.
- Write reg31=16'hA5A5, then read reg31 → Wr_Strb with Wr_Reg_Addr=31, Wr_Data=16'hA5A5; readback 16'hA5A5.
- Write reg0=16'h8000 after setting reg4=16'h0000 → reg0 reads 16'h3100, reg4 reads 16'h01E1.
- Read reg1 with PHY address 5 → Oe stays 0 for the whole frame; the next correctly addressed read of reg1 with Link_Up=1 returns 16'h780D.
- OP=11 frame, and separately a preamble of 31 ones then ST → Frame_Err pulse and no drive for the OP=11 case; no response for the short-preamble case (no response with the macro undefined, response with MDIO_PRE_SUPPRESS_EN).
- Rstn low mid-read during data bit 8 → Oe=0 and O=1 asynchronously; a following full read succeeds.
